// File: rtl/sdac_pkg.sv
// sdac_pkg: shared width and state encoding for the serial DAC transmit path
package sdac_pkg;
  localparam int DATA_W = 12;
  typedef enum logic [1:0] {IDLE, SHIFT, SOC, GAP} sdac_state_t;
endpackage

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-load, shift-left register exposing its MSB
module piso_shift_register #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         msb
);
  logic [N-1:0] q;
  // zeros shift in behind the data, so the MSB idles at 0 once a word has drained
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[N-2:0], 1'b0};
  assign msb = q[N-1];
endmodule

// File: rtl/sdac_serializer.sv
// sdac_serializer: shifts parallel samples MSB-first to the serial DAC, then strobes soc
module sdac_serializer
  import sdac_pkg::*;
#(
  parameter int N   = DATA_W,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         SI,
  output logic         en_SI,
  output logic         soc,
  output logic         busy
);
  localparam int CW = $clog2(N + 1);
  sdac_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] gcnt;
  logic armed, accept, last;
  // armed keeps the release edge from accepting a sample
  assign din_ready = rst_n && armed && state == IDLE;
  assign busy = state != IDLE;
  assign accept = din_valid && din_ready;
  assign last = cnt == CW'(N - 1);
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (accept ? SHIFT : IDLE) :
          state == SHIFT ? (last ? SOC : SHIFT) :
          state == SOC   ? (GAP == 0 ? IDLE : sdac_pkg::GAP) :
                           (gcnt == 4'(GAP - 1) ? IDLE : sdac_pkg::GAP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      en_SI <= 1'b0;
      soc   <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= nxt;
      cnt   <= accept ? '0 : state == SHIFT ? cnt + CW'(1) : cnt;
      gcnt  <= state == sdac_pkg::GAP ? gcnt + 4'd1 : 4'd0;
      en_SI <= nxt == SHIFT;
      soc   <= nxt == SOC;
    end
  piso_shift_register #(.N(N)) u_piso (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .shift(state == SHIFT),
    .d    (din),
    .msb  (SI)
  );
endmodule

// File: tb/tb_sdac_serializer.sv
// tb_sdac_serializer: scoreboard bench with a DAC receiver model for sdac_serializer
module tb_sdac_serializer;
  logic clk = 0, rst_n = 0, dv0 = 0, dv3 = 0;
  logic [11:0] din = '0;
  logic rdy0, si0, en0, soc0, busy0, rdy3, si3, en3, soc3, busy3;
  int checks = 0, failures = 0, cyc = 0, soc_cnt = 0, soc3_cnt = 0, bits = 0;
  int t0, t1, s;
  logic [11:0] rx = '0, head;
  logic [11:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sdac_serializer #(.N(12), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv0), .din_ready(rdy0),
    .SI(si0), .en_SI(en0), .soc(soc0), .busy(busy0)
  );
  sdac_serializer #(.N(12), .GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv3), .din_ready(rdy3),
    .SI(si3), .en_SI(en3), .soc(soc3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // receiver model: captures SI while en_SI, compares the word at soc
  always @(negedge clk) begin
    if (!rst_n) begin
      bits = 0;
      rx = '0;
    end else begin
      if (!en0) check("si_idle", si0, 0);
      if (en0) begin
        if (sb.size() == 0) check("sb_nonempty", 0, 1);
        else begin
          head = sb[0];
          check("si_bit", si0, head[11-bits]);
        end
        rx = {rx[10:0], si0};
        bits++;
      end
      if (soc0) begin
        soc_cnt++;
        check("bit_count", bits, 12);
        if (sb.size() == 0) check("soc_unexpected", 0, 1);
        else check("rx_word", rx, sb.pop_front());
        bits = 0;
      end
    end
    if (soc3) soc3_cnt++;
  end

  task automatic send(input int which, input logic [11:0] w, input bit hold, output int t);
    int n = 0;
    din = w;
    if (which == 3) dv3 = 1; else dv0 = 1;
    while (!(which == 3 ? rdy3 : rdy0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    if (which != 3) sb.push_back(w);
    t = cyc;
    @(negedge clk);
    if (!hold) begin
      dv0 = 0;
      dv3 = 0;
    end
  endtask

  task automatic watch(input bit clobber);
    for (int i = 1; i <= 12; i++) begin
      check("en_si", en0, 1);
      check("ready_low", rdy0, 0);
      if (clobber && i == 2) din = '0;
      @(negedge clk);
    end
    check("soc_pulse", soc0, 1);
    check("en_si_soc", en0, 0);
    check("si_soc", si0, 0);
    check("ready_soc", rdy0, 0);
    @(negedge clk);
    check("soc_single", soc0, 0);
    check("ready_end", rdy0, 1);
    check("busy_end", busy0, 0);
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {si0, en0, soc0, busy0, rdy0}, 0);
    end
    rst_n = 1;
    @(negedge clk);
    check("ready_after_reset", rdy0, 1);
    check("busy_after_reset", busy0, 0);

    send(0, 12'hA5C, 0, t0);
    watch(0);

    send(0, 12'h7FF, 0, t0);
    watch(1);

    s = soc_cnt;
    send(0, 12'hFFF, 1, t0);
    send(0, 12'h000, 0, t1);
    check("b2b_gap0", t1 - t0, 14);
    repeat (14) @(negedge clk);
    check("b2b_gap0_socs", soc_cnt - s, 2);

    s = soc3_cnt;
    send(3, 12'hFFF, 1, t0);
    send(3, 12'h000, 0, t1);
    check("b2b_gap3", t1 - t0, 17);
    repeat (20) @(negedge clk);
    check("b2b_gap3_socs", soc3_cnt - s, 2);
    check("gap3_ready", rdy3, 1);

    send(0, 12'h3C3, 0, t0);
    repeat (6) @(negedge clk);
    s = soc_cnt;
    #2 rst_n = 0;
    sb.delete();
    #1;
    check("rst_mid_outs", {si0, en0, soc0, busy0, rdy0}, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_soc", soc_cnt - s, 0);
    rst_n = 1;
    @(negedge clk);
    send(0, 12'h123, 0, t0);
    watch(0);

    rst_n = 0;
    din = 12'h555;
    dv0 = 1;
    @(negedge clk);
    @(posedge clk) rst_n = 1;
    @(negedge clk);
    check("no_accept_on_release", busy0, 0);
    send(0, 12'h555, 0, t0);
    watch(0);

    s = soc_cnt;
    for (int i = 0; i < 16; i++) send(0, 12'(i * 'h111), i < 15, t0);
    repeat (16) @(negedge clk);
    check("ramp_socs", soc_cnt - s, 16);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
